// File: rtl/packet_arbiter_if.sv
// -----------------------------------------------------------------------------
// packet_arbiter_if
// Handshake bundle for the packet arbiter: N upstream val/rdy payload streams
// in, one tagged val/rdy message stream out.
//
// Signals:
//   valid       [p_ninputs]          input i holds a payload
//   message_in  [p_ninputs][c_pbits] payload per input, element i = input i
//   ready_out   [p_ninputs]          arbiter accepts from input i this cycle
//   valid_out                        output register holds a message
//   message_out [p_nbits]            {src_idx, payload}
//   ready                            downstream can take message_out
//
// Modports:
//   slave  - arbiter side (consumes input streams, produces the output stream)
//   master - environment side (drives input streams and downstream ready)
// -----------------------------------------------------------------------------
interface packet_arbiter_if #(
  parameter int p_nbits   = 8,
  parameter int p_ninputs = 8
);
  localparam int c_sel   = $clog2(p_ninputs);
  localparam int c_pbits = p_nbits - c_sel;

  logic [p_ninputs-1:0]              valid;
  logic [p_ninputs-1:0][c_pbits-1:0] message_in;
  logic [p_ninputs-1:0]              ready_out;
  logic                              valid_out;
  logic [p_nbits-1:0]                message_out;
  logic                              ready;

  modport slave (
    input  valid, message_in, ready,
    output ready_out, valid_out, message_out
  );

  modport master (
    output valid, message_in, ready,
    input  ready_out, valid_out, message_out
  );
endinterface

// File: rtl/packet_arbiter.sv
// -----------------------------------------------------------------------------
// packet_arbiter
// Many-to-one merge stage. Picks one of p_ninputs val/rdy input streams per
// cycle by round-robin, tags the payload with the winning index in the MSBs
// and holds it in a single output register until the downstream takes it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        packet_arbiter_if.slave handshake bundle
//   count_out  (only with PACKET_ARBITER_STATS_EN) saturating 16-bit count of
//              output transfers (valid_out & ready)
//
// Optional feature macro: PACKET_ARBITER_STATS_EN
//
// p_ninputs must be a power of two (>= 2) so the pointer wraps naturally, and
// p_nbits must leave at least one payload bit after the index.
// -----------------------------------------------------------------------------
module packet_arbiter #(
  parameter int p_nbits   = 8,
  parameter int p_ninputs = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef PACKET_ARBITER_STATS_EN
  packet_arbiter_if.slave     bus,
  output logic [15:0]         count_out
`else
  packet_arbiter_if.slave     bus
`endif
);
  localparam int c_sel   = $clog2(p_ninputs);
  localparam int c_pbits = p_nbits - c_sel;

  typedef enum logic [0:0] {
    st_empty = 1'b0,
    st_full  = 1'b1
  } state_t;

  state_t               state_r;
  logic                 valid_out_r;
  logic [p_nbits-1:0]   message_r;
  logic [c_sel-1:0]     ptr_r;

  logic [c_sel-1:0]     grant_s;
  logic [c_sel-1:0]     idx_s;
  logic                 found_s;
  logic                 can_load_s;
  logic                 load_s;
  logic [p_ninputs-1:0] ready_out_s;

  // Round-robin search: first valid input starting at ptr, wrapping around.
  always_comb begin
    grant_s = ptr_r;
    found_s = 1'b0;
    idx_s   = ptr_r;
    for (int k = 0; k < p_ninputs; k++) begin
      // c_sel-bit addition wraps modulo p_ninputs because it is a power of two
      idx_s = ptr_r + c_sel'(k);
      if (!found_s && bus.valid[idx_s]) begin
        grant_s = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake decode: the register can take a new message when empty or when
  // its current occupant leaves on this same edge.
  always_comb begin
    can_load_s  = (state_r == st_empty) || bus.ready;
    load_s      = found_s && can_load_s && !reset;
    ready_out_s = {p_ninputs{1'b0}};
    if (load_s) begin
      ready_out_s[grant_s] = 1'b1;
    end else begin
      ready_out_s = {p_ninputs{1'b0}};
    end
  end

  // Output buffer FSM with its registered outputs and the priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= st_empty;
      valid_out_r <= 1'b0;
      message_r   <= {p_nbits{1'b0}};
      ptr_r       <= {c_sel{1'b0}};
    end else begin
      case (state_r)
        st_empty: begin
          if (load_s) begin
            state_r     <= st_full;
            valid_out_r <= 1'b1;
            message_r   <= {grant_s, bus.message_in[grant_s]};
            ptr_r       <= grant_s + c_sel'(1'b1);
          end else begin
            state_r     <= st_empty;
            valid_out_r <= 1'b0;
          end
        end
        st_full: begin
          if (load_s) begin
            // drain and refill on the same edge keeps one message per cycle
            state_r     <= st_full;
            valid_out_r <= 1'b1;
            message_r   <= {grant_s, bus.message_in[grant_s]};
            ptr_r       <= grant_s + c_sel'(1'b1);
          end else if (bus.ready) begin
            state_r     <= st_empty;
            valid_out_r <= 1'b0;
          end else begin
            state_r     <= st_full;
            valid_out_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= st_empty;
          valid_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out   = ready_out_s;
  assign bus.valid_out   = valid_out_r;
  assign bus.message_out = message_r;

`ifdef PACKET_ARBITER_STATS_EN
  logic [15:0] count_r;

  // Saturating count of messages handed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 16'h0000;
    end else if (valid_out_r && bus.ready && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'h0001;
    end else begin
      count_r <= count_r;
    end
  end

  assign count_out = count_r;
`endif
endmodule

// File: tb/tb_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_packet_arbiter
// Self-checking bench for packet_arbiter (p_nbits=8, p_ninputs=4). A small
// behavioural model (output slot, priority pointer, transfer count) predicts
// ready_out / valid_out / message_out every cycle; directed scenarios pin the
// model with literal values, then a randomized phase exercises back-pressure,
// held requests and sporadic resets.
// -----------------------------------------------------------------------------
module tb_packet_arbiter;
  localparam int NB = 8;
  localparam int NI = 4;

  logic clk;
  logic reset;

  packet_arbiter_if #(.p_nbits(NB), .p_ninputs(NI)) bus ();

`ifdef PACKET_ARBITER_STATS_EN
  logic [15:0] count_out;
  packet_arbiter #(.p_nbits(NB), .p_ninputs(NI)) dut (
    .clk(clk), .reset(reset), .bus(bus), .count_out(count_out)
  );
`else
  packet_arbiter #(.p_nbits(NB), .p_ninputs(NI)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  bit         m_full;
  logic [7:0] m_msg;
  int         m_ptr;
  int         m_cnt;
  logic [3:0] last_ro;

  function automatic int find_grant(input logic [3:0] v, input int p);
    for (int d = 0; d < NI; d++) begin
      if (v[(p + d) % NI]) return (p + d) % NI;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare against the
  // model, then advance the model across the rising edge.
  task automatic tick(input logic [3:0] v, input logic [3:0][5:0] m,
                      input logic r, input logic rst, output int acc);
    int g;
    bit can;
    logic [3:0] exp_ro;
    bus.valid = v;
    bus.message_in = m;
    bus.ready = r;
    reset = rst;
    #1;
    g = find_grant(v, m_ptr);
    can = !m_full || r;
    exp_ro = 4'b0000;
    if (!rst && can && g >= 0) exp_ro[g] = 1'b1;
    last_ro = bus.ready_out;
    chk("ready_out", {28'd0, bus.ready_out}, {28'd0, exp_ro});
    chk("valid_out", {31'd0, bus.valid_out}, {31'd0, m_full});
    if (m_full) chk("message_out", {24'd0, bus.message_out}, {24'd0, m_msg});
`ifdef PACKET_ARBITER_STATS_EN
    chk("count_out", {16'd0, count_out}, m_cnt);
`endif
    acc = -1;
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0; m_msg = 8'h00; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_full && r && m_cnt != 65535) m_cnt++;
      if (can && g >= 0) begin
        m_full = 1'b1;
        m_msg = {g[1:0], m[g]};
        m_ptr = (g + 1) % NI;
        acc = g;
      end else if (m_full && r) begin
        m_full = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  logic [3:0][5:0] mm;
  logic [3:0]      pend;
  logic [3:0][5:0] pdat;
  int              waits [NI];
  int              acc;
  logic [7:0]      seq [8];

  initial begin
    reset = 1'b1;
    bus.valid = 4'b0000;
    bus.message_in = '0;
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_full = 1'b0; m_msg = 8'h00; m_ptr = 0; m_cnt = 0;
    chk("reset_valid_out", {31'd0, bus.valid_out}, 32'd0);
    chk("reset_message_out", {24'd0, bus.message_out}, 32'd0);
    chk("reset_ready_out", {28'd0, bus.ready_out}, 32'd0);

    // 1: single request on input 2
    tick(4'b0000, '0, 1'b0, 1'b0, acc);
    mm = '0; mm[2] = 6'h15;
    tick(4'b0100, mm, 1'b1, 1'b0, acc);
    chk("t1_ready_out", {28'd0, last_ro}, 32'h4);
    chk("t1_valid_out", {31'd0, bus.valid_out}, 32'd1);
    chk("t1_message_out", {24'd0, bus.message_out}, 32'h95);
    tick(4'b1111, '0, 1'b1, 1'b0, acc);
    chk("t1_ptr_is_3", {28'd0, last_ro}, 32'h8);

    // 2: all inputs busy, full throughput with no bubbles
    tick(4'b0000, '0, 1'b1, 1'b1, acc);
    mm = {6'h04, 6'h03, 6'h02, 6'h01};
    seq = '{8'h01, 8'h42, 8'h83, 8'hC4, 8'h01, 8'h42, 8'h83, 8'hC4};
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, mm, 1'b1, 1'b0, acc);
      chk("t2_valid_out", {31'd0, bus.valid_out}, 32'd1);
      chk("t2_message_out", {24'd0, bus.message_out}, {24'd0, seq[i]});
    end

    // 3: back-pressure holds the buffer, then drain+refill on one edge
    tick(4'b0000, '0, 1'b1, 1'b1, acc);
    mm = '0; mm[0] = 6'h01; mm[1] = 6'h02;
    tick(4'b0001, mm, 1'b1, 1'b0, acc);
    tick(4'b0010, mm, 1'b1, 1'b0, acc);
    mm[0] = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      tick(4'b0001, mm, 1'b0, 1'b0, acc);
      chk("t3_stall_ready_out", {28'd0, last_ro}, 32'd0);
      chk("t3_stall_message", {24'd0, bus.message_out}, 32'h42);
    end
    tick(4'b0001, mm, 1'b1, 1'b0, acc);
    chk("t3_refill_ready_out", {28'd0, last_ro}, 32'h1);
    chk("t3_refill_message", {24'd0, bus.message_out}, 32'h2A);

    // 4: pointer wrap from 3 to 0
    tick(4'b0000, '0, 1'b1, 1'b1, acc);
    mm = '0; mm[2] = 6'h05;
    tick(4'b0100, mm, 1'b1, 1'b0, acc);
    mm = '0; mm[3] = 6'h11; mm[0] = 6'h22;
    tick(4'b1001, mm, 1'b1, 1'b0, acc);
    chk("t4_grant3", {28'd0, last_ro}, 32'h8);
    chk("t4_msg3", {24'd0, bus.message_out}, 32'hD1);
    tick(4'b0001, mm, 1'b1, 1'b0, acc);
    chk("t4_grant0", {28'd0, last_ro}, 32'h1);
    chk("t4_msg0", {24'd0, bus.message_out}, 32'h22);
    tick(4'b1111, mm, 1'b1, 1'b0, acc);
    chk("t4_ptr_is_1", {28'd0, last_ro}, 32'h2);

    // 5: reset while FULL and stalled discards the message
    mm = {6'h33, 6'h22, 6'h11, 6'h3F};
    tick(4'b1111, mm, 1'b0, 1'b1, acc);
    chk("t5_ready_out_in_reset", {28'd0, last_ro}, 32'd0);
    chk("t5_valid_out", {31'd0, bus.valid_out}, 32'd0);
    tick(4'b1111, mm, 1'b1, 1'b0, acc);
    chk("t5_ptr_is_0", {28'd0, last_ro}, 32'h1);
    chk("t5_new_message", {24'd0, bus.message_out}, 32'h3F);

`ifdef PACKET_ARBITER_STATS_EN
    // 6: transfer counter, saturation and reset
    tick(4'b0000, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 6; i++) tick(4'b1111, mm, 1'b1, 1'b0, acc);
    chk("t6_count5", {16'd0, count_out}, 32'd5);
    for (int i = 0; i < 65535; i++) tick(4'b1111, mm, 1'b1, 1'b0, acc);
    chk("t6_saturate", {16'd0, count_out}, 32'hFFFF);
    tick(4'b0000, '0, 1'b1, 1'b1, acc);
    chk("t6_reset", {16'd0, count_out}, 32'd0);
`endif

    // randomized traffic: requests held until accepted, random back-pressure
    tick(4'b0000, '0, 1'b1, 1'b1, acc);
    pend = 4'b0000;
    pdat = '0;
    for (int i = 0; i < NI; i++) waits[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic rst;
      for (int i = 0; i < NI; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          pdat[i] = 6'($urandom);
        end
      end
      r = ($urandom % 4) != 0;
      rst = ($urandom % 64) == 0;
      tick(pend, pdat, r, rst, acc);
      if (rst) begin
        for (int i = 0; i < NI; i++) waits[i] = 0;
      end else if (acc >= 0) begin
        chk("fair_wait", {31'd0, waits[acc] <= NI - 1}, 32'd1);
        for (int i = 0; i < NI; i++) begin
          if (pend[i] && i != acc) waits[i]++;
        end
        waits[acc] = 0;
        pend[acc] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
